// File: rtl/ddr3_multipg_xfer_ctrl.sv
// Moves whole DPRAM pages to/from DDR3 over the MIG app interface, one DATA_W word per command.
// Optional stall watchdog: define DDR3_XFER_TIMEOUT_EN.
module ddr3_multipg_xfer_ctrl #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned PG_AW     = 8,
    parameter int unsigned NPG_W     = 3,
    parameter int unsigned ADDR_STEP = 8,
    parameter int unsigned TO_CYC    = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     optype,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [NPG_W-1:0]         req_npg,
    output logic                     ack,
    output logic                     busy,
    output logic                     err,
    input  logic                     app_rdy,
    input  logic                     app_wdf_rdy,
    input  logic                     app_rd_data_valid,
    input  logic [DATA_W-1:0]        app_rd_data,
    output logic [ADDR_W-1:0]        app_addr,
    output logic [2:0]               app_cmd,
    output logic                     app_en,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    output logic [DATA_W-1:0]        app_wdf_data,
    input  logic [DATA_W-1:0]        dpram_dout,
    output logic [DATA_W-1:0]        dpram_din,
    output logic [PG_AW+NPG_W-1:0]   dpram_addr,
    output logic                     dpram_wren
);

    localparam int unsigned DPW = PG_AW + NPG_W;
    localparam int unsigned CW  = DPW + 1;

    typedef enum logic [2:0] {StIdle, StWrFetch, StWrIssue, StRdRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       didx_q, didx_d;
    logic [CW-1:0]       n_q, n_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                cmd_done_q, cmd_done_d;
    logic                wdf_done_q, wdf_done_d;
    logic                dp_wren_q, dp_wren_d;
    logic [DPW-1:0]      dp_waddr_q, dp_waddr_d;
    logic [DATA_W-1:0]   dp_din_q, dp_din_d;
    logic                cmd_fire, wdf_fire;

`ifdef DDR3_XFER_TIMEOUT_EN
    localparam int unsigned TO_CW = $clog2(TO_CYC + 1);
    logic [TO_CW-1:0]    to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
    logic                progress;
`endif

    // Address wraps modulo 2^ADDR_W by truncation.
    assign app_addr   = base_q + ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP);
    assign dpram_addr = dp_wren_q ? dp_waddr_q : idx_q[DPW-1:0];
    assign dpram_din  = dp_din_q;
    assign dpram_wren = dp_wren_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        didx_d       = didx_q;
        n_d          = n_q;
        base_d       = base_q;
        cmd_done_d   = cmd_done_q;
        wdf_done_d   = wdf_done_q;
        dp_wren_d    = 1'b0;
        dp_waddr_d   = dp_waddr_q;
        dp_din_d     = dp_din_q;
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        busy         = 1'b0;
        ack          = 1'b0;
        cmd_fire     = 1'b0;
        wdf_fire     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d      = '0;
                    didx_d     = '0;
                    n_d        = (CW'(req_npg) + CW'(1)) << PG_AW;
                    base_d     = req_addr;
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    state_d    = optype ? StRdRun : StWrFetch;
                end
            end
            StWrFetch: begin
                busy    = 1'b1;
                state_d = StWrIssue;
            end
            StWrIssue: begin
                busy         = 1'b1;
                app_en       = !cmd_done_q;
                app_wdf_wren = !wdf_done_q;
                app_wdf_end  = !wdf_done_q;
                app_wdf_data = dpram_dout;
                cmd_fire     = app_en & app_rdy;
                wdf_fire     = app_wdf_wren & app_wdf_rdy;
                // Command and data retire independently; advance only once both have gone.
                if ((cmd_done_q | cmd_fire) && (wdf_done_q | wdf_fire)) begin
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    idx_d      = idx_q + CW'(1);
                    state_d    = (idx_q == n_q - CW'(1)) ? StDone : StWrFetch;
                end else begin
                    cmd_done_d = cmd_done_q | cmd_fire;
                    wdf_done_d = wdf_done_q | wdf_fire;
                end
            end
            StRdRun: begin
                busy     = 1'b1;
                app_cmd  = 3'b001;
                app_en   = (idx_q != n_q);
                cmd_fire = app_en & app_rdy;
                if (cmd_fire) begin
                    idx_d = idx_q + CW'(1);
                end
                if (app_rd_data_valid) begin
                    dp_wren_d  = 1'b1;
                    dp_waddr_d = didx_q[DPW-1:0];
                    dp_din_d   = app_rd_data;
                    didx_d     = didx_q + CW'(1);
                    if (didx_q == n_q - CW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                ack = 1'b1;
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef DDR3_XFER_TIMEOUT_EN
        err_d    = err_q;
        to_cnt_d = to_cnt_q;
        progress = cmd_fire | wdf_fire | ((state_q == StRdRun) & app_rd_data_valid);
        if (state_q == StIdle && req) begin
            err_d = 1'b0;
        end
        if (state_q == StWrIssue || state_q == StRdRun) begin
            if (progress) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_CW'(TO_CYC - 1)) begin
                to_cnt_d   = '0;
                err_d      = 1'b1;
                cmd_done_d = 1'b0;
                wdf_done_d = 1'b0;
                state_d    = StDone;
            end else begin
                to_cnt_d = to_cnt_q + TO_CW'(1);
            end
        end else if (state_q != StWrFetch) begin
            to_cnt_d = '0;
        end
`endif
    end

`ifdef DDR3_XFER_TIMEOUT_EN
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            didx_q     <= '0;
            n_q        <= '0;
            base_q     <= '0;
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            dp_wren_q  <= 1'b0;
            dp_waddr_q <= '0;
            dp_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            didx_q     <= didx_d;
            n_q        <= n_d;
            base_q     <= base_d;
            cmd_done_q <= cmd_done_d;
            wdf_done_q <= wdf_done_d;
            dp_wren_q  <= dp_wren_d;
            dp_waddr_q <= dp_waddr_d;
            dp_din_q   <= dp_din_d;
        end
    end

endmodule

// File: tb/tb_ddr3_multipg_xfer_ctrl.sv
// Bench for ddr3_multipg_xfer_ctrl: table of transfers plus reset, stray-valid and stall sequences.
module tb_ddr3_multipg_xfer_ctrl;

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned ADDR_W    = 28;
    localparam int unsigned PG_AW     = 8;
    localparam int unsigned NPG_W     = 3;
    localparam int unsigned ADDR_STEP = 8;
    localparam int unsigned TO_CYC    = 16;
    localparam int unsigned DPW       = PG_AW + NPG_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                req = 1'b0;
    logic                optype = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [NPG_W-1:0]    req_npg = '0;
    logic                ack, busy, err;
    logic                app_rdy = 1'b0;
    logic                app_wdf_rdy = 1'b0;
    logic                app_rd_data_valid = 1'b0;
    logic [DATA_W-1:0]   app_rd_data = '0;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en, app_wdf_wren, app_wdf_end;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W-1:0]   dpram_dout = '0;
    logic [DATA_W-1:0]   dpram_din;
    logic [DPW-1:0]      dpram_addr;
    logic                dpram_wren;

    ddr3_multipg_xfer_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PG_AW(PG_AW), .NPG_W(NPG_W),
        .ADDR_STEP(ADDR_STEP), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .optype(optype), .req_addr(req_addr),
        .req_npg(req_npg), .ack(ack), .busy(busy), .err(err), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data(app_rd_data), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .dpram_dout(dpram_dout), .dpram_din(dpram_din), .dpram_addr(dpram_addr),
        .dpram_wren(dpram_wren)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct { logic [DPW-1:0] addr; logic [DATA_W-1:0] data; } dp_t;
    typedef struct { int due; logic [ADDR_W-1:0] addr; } resp_t;
    typedef struct {
        logic op; logic [ADDR_W-1:0] base; logic [NPG_W-1:0] npg; int mode; logic drop;
        int budget; int exp_words; logic exp_err;
    } vec_t;

    cmd_t              cmd_q[$];
    logic [DATA_W-1:0] wdf_q[$];
    dp_t               dp_q[$];
    resp_t             resp_q[$];

    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lag = 100;
    int   cmd_cnt = 0;
    int   dp_cnt = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random with wdf leading cmd, 2: stalled
    logic stray = 1'b0;

    function automatic logic [DATA_W-1:0] wpat(input logic [DPW-1:0] a);
        return {4{21'h0ACE5, a}};
    endfunction

    function automatic logic [DATA_W-1:0] rpat(input logic [ADDR_W-1:0] a);
        return {4{~a[3:0], a}};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Registered-output DPRAM holding a known pattern.
    always @(posedge clk) dpram_dout <= wpat(dpram_addr);

    // Ready/response driver; handshakes are taken from pre-edge values.
    always @(posedge clk) begin : drv
        logic  wdf_hit;
        resp_t r;
        wdf_hit = app_wdf_wren && app_wdf_rdy;
        cyc = cyc + 1;
        if (wdf_hit) lag = 1;
        else if (lag < 1000) lag = lag + 1;
        #1;
        case (rdy_mode)
            0: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
            1: begin
                app_wdf_rdy = ($urandom_range(0, 3) != 0);
                app_rdy     = (lag >= 3) && ($urandom_range(0, 3) != 0);
            end
            default: begin app_rdy = 1'b0; app_wdf_rdy = 1'b0; end
        endcase
        if (rst_n && resp_q.size() > 0 && resp_q[0].due == cyc) begin
            r = resp_q.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data       = rpat(r.addr);
        end else if (stray) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = '1;
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data       = '0;
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        cmd_t  ce;
        dp_t   de;
        resp_t r;
        if (rst_n) begin
            if (app_en && app_rdy) begin
                cmd_cnt++;
                if (cmd_q.size() == 0) fail_now("cmd_extra");
                else begin
                    ce = cmd_q.pop_front();
                    check("cmd_addr", DATA_W'(app_addr), DATA_W'(ce.addr));
                    check("cmd_op", DATA_W'(app_cmd), DATA_W'(ce.cmd));
                end
                if (app_cmd == 3'b001) begin
                    r.due  = cyc + 5;
                    r.addr = app_addr;
                    resp_q.push_back(r);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (wdf_q.size() == 0) fail_now("wdf_extra");
                else begin
                    check("wdf_data", app_wdf_data, wdf_q.pop_front());
                    check("wdf_end", DATA_W'(app_wdf_end), DATA_W'(1));
                end
            end
            if (dpram_wren) begin
                dp_cnt++;
                if (dp_q.size() == 0) fail_now("dp_extra");
                else begin
                    de = dp_q.pop_front();
                    check("dp_addr", DATA_W'(dpram_addr), DATA_W'(de.addr));
                    check("dp_data", dpram_din, de.data);
                end
            end
        end
    end

    task automatic start_xfer(input logic op, input logic [ADDR_W-1:0] base,
                              input logic [NPG_W-1:0] npg);
        cmd_t ce;
        dp_t  de;
        int   n;
        n = (int'(npg) + 1) << PG_AW;
        for (int i = 0; i < n; i++) begin
            ce.addr = base + ADDR_W'(i * ADDR_STEP);
            ce.cmd  = op ? 3'b001 : 3'b000;
            cmd_q.push_back(ce);
            if (op) begin
                de.addr = DPW'(i);
                de.data = rpat(ce.addr);
                dp_q.push_back(de);
            end else begin
                wdf_q.push_back(wpat(DPW'(i)));
            end
        end
        cmd_cnt = 0;
        dp_cnt  = 0;
        @(posedge clk);
        #1;
        optype   = op;
        req_addr = base;
        req_npg  = npg;
        req      = 1'b1;
    endtask

    task automatic wait_ack(input int budget, input string name);
        int k;
        k = 0;
        while (!ack && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_ack"}, DATA_W'(ack), DATA_W'(1));
    endtask

    task automatic end_xfer(input string name);
        if (req) begin
            @(posedge clk);
            #1 req = 1'b0;
            @(negedge clk);
            check({name, "_ack_hold"}, DATA_W'(ack), DATA_W'(1));
        end
        @(negedge clk);
        check({name, "_ack_clear"}, DATA_W'(ack), DATA_W'(0));
        check({name, "_cmd_left"}, DATA_W'(cmd_q.size()), DATA_W'(0));
        check({name, "_wdf_left"}, DATA_W'(wdf_q.size()), DATA_W'(0));
        check({name, "_dp_left"}, DATA_W'(dp_q.size()), DATA_W'(0));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        rdy_mode = v.mode;
        start_xfer(v.op, v.base, v.npg);
        @(negedge clk);
        @(negedge clk);
        check({name, "_busy_mid"}, DATA_W'(busy), DATA_W'(1));
        if (v.drop) begin
            @(posedge clk);
            #1 req = 1'b0;
        end
        wait_ack(v.budget, name);
        check({name, "_busy_done"}, DATA_W'(busy), DATA_W'(0));
        check({name, "_err"}, DATA_W'(err), DATA_W'(v.exp_err));
        end_xfer(name);
        check({name, "_ncmd"}, DATA_W'(cmd_cnt), DATA_W'(v.exp_words));
    endtask

    task automatic flush_sb();
        cmd_q.delete();
        wdf_q.delete();
        dp_q.delete();
        resp_q.delete();
    endtask

    vec_t vecs[5];
    int   first_ack;

    initial begin
        vecs[0] = '{1'b0, 28'h0000100, 3'd0, 0, 1'b0, 3000, 256, 1'b0};   // write, full rate
        vecs[1] = '{1'b1, 28'h0002000, 3'd1, 0, 1'b0, 3000, 512, 1'b0};   // read, 2 pages
        vecs[2] = '{1'b0, 28'h0040000, 3'd0, 1, 1'b0, 20000, 256, 1'b0};  // write, backpressure
        vecs[3] = '{1'b0, 28'hFFFFFF8, 3'd0, 0, 1'b0, 3000, 256, 1'b0};   // write, address wrap
        vecs[4] = '{1'b1, 28'hFFFFFF8, 3'd0, 0, 1'b1, 3000, 256, 1'b0};   // read, wrap, req drops

        #1 rst_n = 1'b0;
        #1;
        check("rst_ctl", DATA_W'({ack, busy, err, app_en, app_wdf_wren, dpram_wren}), '0);
        check("rst_app_addr", DATA_W'(app_addr), '0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", DATA_W'(busy), '0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Valid outside RD_RUN must not reach the DPRAM.
        @(negedge clk) stray = 1'b1;
        @(negedge clk) stray = 1'b0;
        @(negedge clk);
        check("stray_wren", DATA_W'(dpram_wren), '0);

        // Reset in the middle of a read.
        rdy_mode = 0;
        start_xfer(1'b1, 28'h0000800, 3'd0);
        first_ack = 0;
        while (dp_cnt < 100 && first_ack < 3000) begin
            @(negedge clk);
            first_ack++;
        end
        check("rst_at_word100", DATA_W'(dp_cnt), DATA_W'(100));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl",
              DATA_W'({ack, busy, err, app_en, app_wdf_wren, app_wdf_end, dpram_wren, app_cmd}),
              '0);
        check("rst_mid_addr", DATA_W'(app_addr), '0);
        check("rst_mid_dpaddr", DATA_W'(dpram_addr), '0);
        check("rst_mid_din", dpram_din, '0);
        check("rst_mid_wdata", app_wdf_data, '0);
        flush_sb();
        req = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_ack", DATA_W'(ack), '0);
        run_vec('{1'b1, 28'h0000600, 3'd0, 0, 1'b0, 3000, 256, 1'b0}, "post_rst");

        // Stalled write.
        rdy_mode = 2;
        start_xfer(1'b0, 28'h0001000, 3'd0);
`ifdef DDR3_XFER_TIMEOUT_EN
        first_ack = -1;
        for (int i = 0; i < 40 && first_ack < 0; i++) begin
            @(negedge clk);
            if (ack) first_ack = i;
        end
        check("to_ack_cycle", DATA_W'(first_ack), DATA_W'(18));
        check("to_err", DATA_W'(err), DATA_W'(1));
        check("to_strobes", DATA_W'({busy, app_en, app_wdf_wren, dpram_wren}), '0);
        flush_sb();
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run_vec(vecs[0], "after_to");
`else
        repeat (40) @(negedge clk);
        check("stall_busy", DATA_W'(busy), DATA_W'(1));
        check("stall_ack", DATA_W'(ack), '0);
        check("stall_err", DATA_W'(err), '0);
        rdy_mode = 0;
        wait_ack(3000, "stall");
        end_xfer("stall");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
